// File: rtl/matrix_pkg.sv
// Shared sizing, state encoding and bus layout for the 3x3 matrix operand loader.
package matrix_pkg;
  localparam int DATA_W   = 16;
  localparam int N        = 3;
  localparam int NUM_ELEM = N * N;
  localparam int CNT_W    = 5;
  localparam int IDX_W    = $clog2(NUM_ELEM);
  localparam int RC_W     = $clog2(N);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  // Bit offset of element (r,c) inside a flat row-major matrix bus.
  function automatic int elem_lsb(input int r, input int c);
    return (r * N + c) * DATA_W;
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// Row/col element counter over an NxN matrix; idx is combinational from the count, wrap flags the last element.
// Transpose select swaps row/col so a column-major stream lands at row-major positions.
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             transpose_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             wrap_o
);
  localparam logic [RC_W-1:0] LAST = RC_W'(N - 1);

  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign wrap_o = (row_q == LAST) && (col_q == LAST);
  assign idx_o  = transpose_i ? (IDX_W'(col_q) * IDX_W'(N) + IDX_W'(row_q))
                              : (IDX_W'(row_q) * IDX_W'(N) + IDX_W'(col_q));
endmodule

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel loader for A then B (18 elements); mat_valid one cycle after the 18th transfer, held until mat_ack.
// in_ready is registered and drops in FULL; MATLD_TRANSPOSE_B_EN selects a column-major B stream.
module matrix_operand_loader
  import matrix_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic [NUM_ELEM*DATA_W-1:0]   mat_a,
  output logic [NUM_ELEM*DATA_W-1:0]   mat_b,
  output logic                         mat_valid,
  input  logic                         mat_ack,
  output logic [CNT_W-1:0]             load_cnt
);
  state_t                       state_q;
  logic                         in_ready_q;
  logic                         mat_valid_q;
  logic [CNT_W-1:0]             load_cnt_q;
  logic [NUM_ELEM*DATA_W-1:0]   mat_a_q;
  logic [NUM_ELEM*DATA_W-1:0]   mat_b_q;

  logic             xfer;
  logic             transpose;
  logic [IDX_W-1:0] idx;
  logic             wrap;
  logic [NUM_ELEM-1:0] en_a;
  logic [NUM_ELEM-1:0] en_b;

  assign xfer = in_valid & in_ready_q;

`ifdef MATLD_TRANSPOSE_B_EN
  assign transpose = (state_q == LOAD_B);
`else
  assign transpose = 1'b0;
`endif

  matrix_index_counter u_idx (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .inc_i       (xfer),
    .transpose_i (transpose),
    .idx_o       (idx),
    .wrap_o      (wrap)
  );

  always_comb begin
    en_a = '0;
    en_b = '0;
    if (xfer && !clr && state_q == LOAD_A) en_a = {{(NUM_ELEM-1){1'b0}}, 1'b1} << idx;
    if (xfer && !clr && state_q == LOAD_B) en_b = {{(NUM_ELEM-1){1'b0}}, 1'b1} << idx;
  end

  // in_ready/mat_valid are registered from the next state, so in_ready never depends on in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      in_ready_q  <= 1'b0;
      mat_valid_q <= 1'b0;
      load_cnt_q  <= '0;
    end else if (clr) begin
      state_q     <= LOAD_A;
      in_ready_q  <= 1'b1;
      mat_valid_q <= 1'b0;
      load_cnt_q  <= '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            load_cnt_q <= load_cnt_q + CNT_W'(1);
            if (wrap) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            load_cnt_q <= load_cnt_q + CNT_W'(1);
            if (wrap) begin
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              mat_valid_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (mat_ack) begin
            state_q     <= LOAD_A;
            in_ready_q  <= 1'b1;
            mat_valid_q <= 1'b0;
            load_cnt_q  <= '0;
          end
        end
        default: begin
          state_q     <= LOAD_A;
          in_ready_q  <= 1'b1;
          mat_valid_q <= 1'b0;
          load_cnt_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (en_a[r*N+c]) mat_a_q[elem_lsb(r, c) +: DATA_W] <= in_data;
          if (en_b[r*N+c]) mat_b_q[elem_lsb(r, c) +: DATA_W] <= in_data;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mat_valid = mat_valid_q;
  assign load_cnt  = load_cnt_q;
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboarded bench for matrix_operand_loader: stream, backpressure, clr, async reset, B ordering, multiply.
module tb_matrix_operand_loader;
  logic         clk = 1'b0;
  logic         rst, clr, in_valid, in_ready, mat_valid, mat_ack;
  logic [15:0]  in_data;
  logic [143:0] mat_a, mat_b;
  logic [4:0]   load_cnt;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic [143:0] qa[$];
  logic [143:0] qb[$];
  logic [15:0]  sa[9];
  logic [15:0]  sb[9];

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mat_a(mat_a), .mat_b(mat_b), .mat_valid(mat_valid),
    .mat_ack(mat_ack), .load_cnt(load_cnt)
  );

  function automatic logic [15:0] el(input logic [143:0] m, input int r, input int c);
    return m[(r*3+c)*16 +: 16];
  endfunction

  // Row-major position of the k-th streamed B element.
  function automatic int bpos(input int k);
`ifdef MATLD_TRANSPOSE_B_EN
    return (k % 3) * 3 + k / 3;
`else
    return k;
`endif
  endfunction

  task automatic send_elem(input logic [15:0] d, input bit gap);
    int to = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1; edges++;
    end
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && to < 100) begin
      @(posedge clk); #1; to++; edges++;
    end
    checks++;
    if (to >= 100) begin
      errors++;
      $display("FAIL in_ready_timeout got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1; edges++;
  endtask

  task automatic send_set(input bit gap);
    logic [143:0] ea, eb;
    ea = '0; eb = '0;
    for (int k = 0; k < 9; k++) begin
      ea[k*16 +: 16]       = sa[k];
      eb[bpos(k)*16 +: 16] = sb[k];
    end
    qa.push_back(ea);
    qb.push_back(eb);
    edges = 0;
    for (int k = 0; k < 18; k++) begin
      send_elem((k < 9) ? sa[k] : sb[k-9], gap);
      if (k < 17) begin
        checks++;
        if (mat_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_mat_valid after transfer %0d got %b want 0", k + 1, mat_valid);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_ack();
    mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; mat_ack = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (mat_valid !== 1'b0) begin errors++; $display("FAIL rst_mat_valid got %b want 0", mat_valid); end
    checks++; if (load_cnt !== 5'd0) begin errors++; $display("FAIL rst_load_cnt got %0d want 0", load_cnt); end
    checks++; if (mat_a !== '0) begin errors++; $display("FAIL rst_mat_a got %h want 0", mat_a); end
    checks++; if (mat_b !== '0) begin errors++; $display("FAIL rst_mat_b got %h want 0", mat_b); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [143:0] ea, eb;
    for (int k = 0; k < 9; k++) begin sa[k] = 16'(k + 1); sb[k] = 16'(k + 10); end
    send_set(1'b0);
    checks++; if (edges != 18) begin errors++; $display("FAIL stream_latency got %0d edges want 18", edges); end
    checks++; if (mat_valid !== 1'b1) begin errors++; $display("FAIL stream_mat_valid got %b want 1", mat_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    checks++; if (load_cnt !== 5'd18) begin errors++; $display("FAIL full_load_cnt got %0d want 18", load_cnt); end
    checks++; if (el(mat_a, 0, 0) !== 16'd1) begin errors++; $display("FAIL a00 got %0d want 1", el(mat_a, 0, 0)); end
    checks++; if (el(mat_a, 2, 2) !== 16'd9) begin errors++; $display("FAIL a22 got %0d want 9", el(mat_a, 2, 2)); end
    checks++; if (el(mat_b, 2, 2) !== 16'd18) begin errors++; $display("FAIL b22 got %0d want 18", el(mat_b, 2, 2)); end
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++; if (mat_a !== ea) begin errors++; $display("FAIL stream_a got %h want %h", mat_a, ea); end
    checks++; if (mat_b !== eb) begin errors++; $display("FAIL stream_b got %h want %h", mat_b, eb); end
    do_ack();
    checks++; if (mat_valid !== 1'b0) begin errors++; $display("FAIL ack_mat_valid got %b want 0", mat_valid); end
    checks++; if (load_cnt !== 5'd0) begin errors++; $display("FAIL ack_load_cnt got %0d want 0", load_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ack_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [143:0] ea, eb;
    for (int k = 0; k < 9; k++) begin sa[k] = 16'(k + 20); sb[k] = 16'(k + 30); end
    send_set(1'b1);
    checks++; if (mat_valid !== 1'b1) begin errors++; $display("FAIL bp_mat_valid got %b want 1", mat_valid); end
    ea = qa.pop_front(); eb = qb.pop_front();
    in_valid = 1'b1; in_data = 16'h0100; mat_ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
      checks++; if (mat_a !== ea) begin errors++; $display("FAIL bp_a cycle %0d got %h want %h", i, mat_a, ea); end
      checks++; if (mat_b !== eb) begin errors++; $display("FAIL bp_b cycle %0d got %h want %h", i, mat_b, eb); end
    end
    do_ack();
    checks++; if (load_cnt !== 5'd0) begin errors++; $display("FAIL ack_edge_no_xfer got %0d want 0", load_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ack_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (load_cnt !== 5'd1) begin errors++; $display("FAIL post_ack_xfer got %0d want 1", load_cnt); end
    checks++; if (el(mat_a, 0, 0) !== 16'h0100) begin errors++; $display("FAIL post_ack_a00 got %h want 0100", el(mat_a, 0, 0)); end
    in_valid = 1'b0;
  endtask

  task automatic test_clr();
    logic [143:0] ea, eb;
    for (int i = 0; i < 11; i++) send_elem(16'(16'h0200 + i), 1'b0);
    checks++; if (load_cnt !== 5'd12) begin errors++; $display("FAIL pre_clr_cnt got %0d want 12", load_cnt); end
    in_data = 16'h1234; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (load_cnt !== 5'd0) begin errors++; $display("FAIL clr_load_cnt got %0d want 0", load_cnt); end
    checks++; if (mat_valid !== 1'b0) begin errors++; $display("FAIL clr_mat_valid got %b want 0", mat_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready got %b want 1", in_ready); end
    checks++; if (el(mat_a, 0, 0) !== 16'h0100) begin errors++; $display("FAIL clr_keeps_a00 got %h want 0100", el(mat_a, 0, 0)); end
    checks++; if (el(mat_a, 2, 2) !== 16'h0207) begin errors++; $display("FAIL clr_keeps_a22 got %h want 0207", el(mat_a, 2, 2)); end
    checks++; if (mat_b[bpos(3)*16 +: 16] !== 16'd33) begin errors++; $display("FAIL clr_drop_xfer got %h want 0021", mat_b[bpos(3)*16 +: 16]); end
    for (int k = 0; k < 9; k++) begin sa[k] = 16'hFFFF; sb[k] = 16'hFFFF; end
    send_set(1'b0);
    checks++; if (mat_valid !== 1'b1) begin errors++; $display("FAIL ones_mat_valid got %b want 1", mat_valid); end
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++; if (mat_a !== ea) begin errors++; $display("FAIL ones_a got %h want %h", mat_a, ea); end
    checks++; if (mat_b !== eb) begin errors++; $display("FAIL ones_b got %h want %h", mat_b, eb); end
    do_ack();
  endtask

  task automatic test_async_reset();
    logic [143:0] ea, eb;
    for (int k = 0; k < 9; k++) begin sa[k] = 16'(k + 50); sb[k] = 16'(k + 60); end
    for (int k = 0; k < 9; k++) send_elem(sa[k], 1'b0);
    for (int k = 0; k < 4; k++) send_elem(sb[k], 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++; if (mat_valid !== 1'b0) begin errors++; $display("FAIL arst_mat_valid got %b want 0", mat_valid); end
    checks++; if (load_cnt !== 5'd0) begin errors++; $display("FAIL arst_load_cnt got %0d want 0", load_cnt); end
    checks++; if (mat_a !== '0) begin errors++; $display("FAIL arst_mat_a got %h want 0", mat_a); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready got %b want 0", in_ready); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_set(1'b0);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++; if (el(mat_a, 0, 0) !== 16'd50) begin errors++; $display("FAIL arst_restart_a00 got %0d want 50", el(mat_a, 0, 0)); end
    checks++; if (mat_a !== ea) begin errors++; $display("FAIL arst_a got %h want %h", mat_a, ea); end
    checks++; if (mat_b !== eb) begin errors++; $display("FAIL arst_b got %h want %h", mat_b, eb); end
    do_ack();
  endtask

  task automatic test_transpose();
    logic [143:0] ea, eb;
    logic [15:0]  w10, w01;
`ifdef MATLD_TRANSPOSE_B_EN
    w10 = 16'd11; w01 = 16'd13;
`else
    w10 = 16'd13; w01 = 16'd11;
`endif
    for (int k = 0; k < 9; k++) begin
      sa[k] = (k == 0 || k == 4 || k == 8) ? 16'd1 : 16'd0;
      sb[k] = 16'(k + 10);
    end
    send_set(1'b0);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++; if (el(mat_b, 1, 0) !== w10) begin errors++; $display("FAIL b10 got %0d want %0d", el(mat_b, 1, 0), w10); end
    checks++; if (el(mat_b, 0, 1) !== w01) begin errors++; $display("FAIL b01 got %0d want %0d", el(mat_b, 0, 1), w01); end
    checks++; if (el(mat_b, 2, 2) !== 16'd18) begin errors++; $display("FAIL tr_b22 got %0d want 18", el(mat_b, 2, 2)); end
    checks++; if (mat_b !== eb) begin errors++; $display("FAIL tr_b got %h want %h", mat_b, eb); end
    checks++; if (mat_a !== ea) begin errors++; $display("FAIL tr_a got %h want %h", mat_a, ea); end
    do_ack();
  endtask

  task automatic test_multiply();
    logic [143:0] ea, eb;
    logic [15:0]  acc, want;
    for (int k = 0; k < 9; k++) begin
      sa[k] = (k == 0 || k == 4 || k == 8) ? 16'd1 : 16'd0;
      sb[k] = 16'(k + 1);
    end
    send_set(1'b0);
    ea = qa.pop_front(); eb = qb.pop_front();
    for (int cyc = 0; cyc < 3; cyc++) begin
      checks++; if (mat_valid !== 1'b1) begin errors++; $display("FAIL mul_mat_valid got %b want 1", mat_valid); end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          acc = '0;
          for (int k = 0; k < 3; k++) acc = acc + el(mat_a, r, k) * el(mat_b, k, c);
`ifdef MATLD_TRANSPOSE_B_EN
          want = 16'(c * 3 + r + 1);
`else
          want = 16'(r * 3 + c + 1);
`endif
          checks++;
          if (acc !== want) begin errors++; $display("FAIL mul_c%0d%0d got %0d want %0d", r, c, acc, want); end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (mat_b !== eb) begin errors++; $display("FAIL mul_b got %h want %h", mat_b, eb); end
    do_ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_transpose();
    test_multiply();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
